// File: rtl/axi4_mem_slave_responder.sv
// rtl/axi4_mem_slave_responder.sv - AXI4 slave answering FIXED/INCR/WRAP bursts from an internal word memory
//
// Ports:
//   aclk, areset                  clock, asynchronous active-high reset
//   aw*  (id/addr/len/burst)      write address channel, awvalid/awready handshake
//   w*   (data/strb/last)         write data channel, wvalid/wready handshake
//   b*   (id/resp)                write response channel, bvalid/bready handshake
//   ar*  (id/addr/len/burst)      read address channel, arvalid/arready handshake
//   r*   (id/data/resp/last)      read data channel, rvalid/rready handshake
module axi4_mem_slave_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 10
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int B  = $clog2(NB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

    w_state_t          w_state, w_next;
    logic [MEM_AW-1:0] w_idx;
    logic [7:0]        w_len, w_beat;
    logic [1:0]        w_burst;
    logic              w_err;
    logic              w_beat_last, w_beat_err;

    r_state_t          r_state, r_next;
    logic [MEM_AW-1:0] r_idx;
    logic [7:0]        r_len, r_beat;
    logic [1:0]        r_burst;

    logic [MEM_AW-1:0] aw_idx, ar_idx;
    logic              unused_addr_bits;

    // Full-size beats: byte lanes and bits above the memory index are ignored (aliasing).
    assign aw_idx = awaddr[MEM_AW+B-1:B];
    assign ar_idx = araddr[MEM_AW+B-1:B];
    assign unused_addr_bits = ^{awaddr[B-1:0], awaddr[ADDR_WIDTH-1:MEM_AW+B],
                                araddr[B-1:0], araddr[ADDR_WIDTH-1:MEM_AW+B]};

    function automatic logic wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok(len));
    endfunction

    // Next word index; a valid WRAP keeps the upper bits and counts only inside the len-sized block.
    function automatic logic [MEM_AW-1:0] step_idx(input logic [MEM_AW-1:0] idx,
                                                   input logic [7:0] len,
                                                   input logic [1:0] burst);
        logic [MEM_AW-1:0] inc, mask;
        inc  = idx + MEM_AW'(1);
        mask = MEM_AW'(len);
        if (burst == 2'b00)
            return idx;
        else if (burst == 2'b10 && wrap_ok(len))
            return (idx & ~mask) | (inc & mask);
        else
            return inc;
    endfunction

    assign w_beat_last = (w_beat == w_len);
    assign w_beat_err  = (wlast != w_beat_last);

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_beat_last) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            bid     <= '0;
            bresp   <= 2'b00;
        end else begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: if (awvalid) begin
                    w_idx   <= aw_idx;
                    w_len   <= awlen;
                    w_burst <= awburst;
                    w_beat  <= '0;
                    w_err   <= burst_err(awburst, awlen);
                    bid     <= awid;
                end
                W_DATA: if (wvalid) begin
                    w_idx  <= step_idx(w_idx, w_len, w_burst);
                    w_beat <= w_beat + 8'd1;
                    w_err  <= w_err | w_beat_err;
                    if (w_beat_last) bresp <= (w_err | w_beat_err) ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    // Memory is never reset; reserved-burst writes are dropped.
    always_ff @(posedge aclk) begin
        if (w_state == W_DATA && wvalid && w_burst != 2'b11) begin
            for (int i = 0; i < NB; i++)
                if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // The next word is fetched on the same edge that retires the current beat, giving one beat per cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
        end else begin
            r_state <= r_next;
            case (r_state)
                R_IDLE: if (arvalid) begin
                    rid     <= arid;
                    rresp   <= burst_err(arburst, arlen) ? 2'b10 : 2'b00;
                    rlast   <= (arlen == 8'd0);
                    rdata   <= (arburst == 2'b11) ? '0 : mem[ar_idx];
                    r_idx   <= step_idx(ar_idx, arlen, arburst);
                    r_len   <= arlen;
                    r_burst <= arburst;
                    r_beat  <= '0;
                end
                R_DATA: if (rready) begin
                    if (rlast) begin
                        rlast <= 1'b0;
                    end else begin
                        rdata  <= (r_burst == 2'b11) ? '0 : mem[r_idx];
                        r_idx  <= step_idx(r_idx, r_len, r_burst);
                        r_beat <= r_beat + 8'd1;
                        rlast  <= ((r_beat + 8'd1) == r_len);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_mem_slave_responder.sv
// tb/tb_axi4_mem_slave_responder.sv - self-checking bench for axi4_mem_slave_responder
module tb_axi4_mem_slave_responder;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int fails  = 0;

    logic [31:0] model [0:1023];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic [31:0] rd_data [$];
    logic [1:0]  rd_resp [$];
    logic        rd_last [$];

    always #5 aclk = ~aclk;

    axi4_mem_slave_responder dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // Reference model: addresses and responses from the burst rules in plain arithmetic.
    function automatic bit wrap_len_ok(int len);
        return len == 1 || len == 3 || len == 7 || len == 15;
    endfunction

    function automatic int beat_index(int start, int len, int burst, int k);
        int n, base;
        if (burst == 0) return start;
        if (burst == 2 && wrap_len_ok(len)) begin
            n = len + 1;
            base = start - (start % n);
            return base + ((start % n) + k) % n;
        end
        return (start + k) % 1024;
    endfunction

    function automatic logic [1:0] exp_resp(int burst, int len);
        return (burst == 3 || (burst == 2 && !wrap_len_ok(len))) ? 2'b10 : 2'b00;
    endfunction

    function automatic void model_write(int start, int len, int burst);
        int idx;
        if (burst == 3) return;
        for (int k = 0; k <= len; k++) begin
            idx = beat_index(start, len, burst, k);
            for (int b = 0; b < 4; b++)
                if (wq_strb[k][b]) model[idx][8*b +: 8] = wq_data[k][8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(int start, int len, int burst, int k);
        if (burst == 3) return 32'h0;
        return model[beat_index(start, len, burst, k)];
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int last_at, input int bstall,
                             output logic [1:0] resp_o, output logic [3:0] id_o, output int bad_hold);
        int wc;
        wc = 0;
        bad_hold = 0;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len[7:0]; awburst = burst; awvalid = 1'b1;
        while (awready !== 1'b1 && wc < 300) begin @(negedge aclk); wc++; end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            wdata = wq_data[k]; wstrb = wq_strb[k]; wlast = (k == last_at); wvalid = 1'b1;
            while (wready !== 1'b1 && wc < 300) begin @(negedge aclk); wc++; end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = (bstall == 0);
        while (bvalid !== 1'b1 && wc < 300) begin @(negedge aclk); wc++; end
        for (int s = 0; s < bstall; s++) begin
            if (bvalid !== 1'b1 || awready !== 1'b0) bad_hold++;
            @(negedge aclk);
        end
        bready = 1'b1;
        resp_o = bresp; id_o = bid;
        @(negedge aclk);
        bready = 1'b0;
        if (wc >= 300) begin
            checks++; fails++;
            $display("FAIL write_timeout: handshake budget exhausted, got %0d cycles, required < 300", wc);
        end
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int stall_beat, input int stall_cycles,
                            output logic [3:0] rid_o, output int unstable, output int cycles,
                            output logic first_ok);
        int wc, beat, stall;
        logic [38:0] snap;
        wc = 0; beat = 0; unstable = 0; cycles = 0; rid_o = '0; stall = stall_cycles;
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len[7:0]; arburst = burst; arvalid = 1'b1; rready = 1'b1;
        while (arready !== 1'b1 && wc < 100) begin @(negedge aclk); wc++; end
        @(negedge aclk);
        arvalid = 1'b0;
        first_ok = (rvalid === 1'b1);
        while (beat <= len && cycles < 500) begin
            if (rvalid === 1'b1) begin
                if (beat == stall_beat && stall > 0) begin
                    rready = 1'b0;
                    snap = {rdata, rresp, rlast, rid};
                    for (int s = 0; s < stall; s++) begin
                        @(negedge aclk); cycles++;
                        if (rvalid !== 1'b1 || {rdata, rresp, rlast, rid} !== snap) unstable++;
                    end
                    stall = 0;
                    rready = 1'b1;
                end
                rd_data.push_back(rdata); rd_resp.push_back(rresp); rd_last.push_back(rlast);
                rid_o = rid;
                beat++;
            end
            @(negedge aclk); cycles++;
        end
        if (wc >= 100 || cycles >= 500) begin
            checks++; fails++;
            $display("FAIL read_timeout: got %0d beats, required %0d", beat, len + 1);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge aclk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 110000", {awready, arready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if ({bid, rid, bresp, rresp, rdata} !== 44'h0) begin
            fails++;
            $display("FAIL reset_data: got %h, required 0", {bid, rid, bresp, rresp, rdata});
        end
        areset = 1'b0;
    endtask

    task automatic init_mem();
        logic [1:0] r; logic [3:0] i; int h;
        wq_data.delete(); wq_strb.delete();
        for (int k = 0; k < 64; k++) begin wq_data.push_back(32'h0); wq_strb.push_back(4'hF); end
        axi_write(4'h0, 32'h0, 63, 2'b01, 63, 0, r, i, h);
        model_write(0, 63, 1);
    endtask

    task automatic test_incr();
        logic [1:0] r; logic [3:0] i; int h, unst, cyc; logic f;
        wq_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(4'h5, 32'h10, 3, 2'b01, 3, 0, r, i, h);
        checks++; if (r !== 2'b00) begin fails++; $display("FAIL incr_bresp: got %b, required 00", r); end
        checks++; if (i !== 4'h5) begin fails++; $display("FAIL incr_bid: got %h, required 5", i); end
        model_write(4, 3, 1);
        axi_read(4'hA, 32'h10, 3, 2'b01, -1, 0, i, unst, cyc, f);
        checks++; if (f !== 1'b1) begin fails++; $display("FAIL incr_first_latency: rvalid got %b, required 1", f); end
        checks++; if (rd_data.size() != 4) begin fails++; $display("FAIL incr_beats: got %0d, required 4", rd_data.size()); end
        for (int k = 0; k < 4 && k < rd_data.size(); k++) begin
            checks++;
            if ({rd_data[k], rd_resp[k], rd_last[k]} !== {32'h11111111 * (k + 1), 2'b00, k == 3}) begin
                fails++;
                $display("FAIL incr_beat%0d: got %h/%b/%b, required %h/00/%b", k, rd_data[k], rd_resp[k], rd_last[k], 32'h11111111 * (k + 1), k == 3);
            end
        end
        checks++; if (i !== 4'hA) begin fails++; $display("FAIL incr_rid: got %h, required a", i); end
        checks++; if (cyc != 4) begin fails++; $display("FAIL incr_rate: got %0d cycles, required 4", cyc); end
        checks++; if ({rvalid, arready} !== 2'b01) begin fails++; $display("FAIL incr_after: rvalid/arready got %b, required 01", {rvalid, arready}); end
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [3:0] i; int h, unst, cyc; logic f;
        wq_data = '{32'h0}; wq_strb = '{4'hF};
        axi_write(4'h1, 32'h20, 0, 2'b01, 0, 0, r, i, h);
        model_write(8, 0, 1);
        wq_data = '{32'hAABBCCDD}; wq_strb = '{4'b0101};
        axi_write(4'h2, 32'h20, 0, 2'b01, 0, 0, r, i, h);
        model_write(8, 0, 1);
        axi_read(4'h3, 32'h20, 0, 2'b01, -1, 0, i, unst, cyc, f);
        checks++;
        if (rd_data.size() != 1 || rd_data[0] !== 32'h00BB00DD || rd_last[0] !== 1'b1) begin
            fails++;
            $display("FAIL strobe_merge: got %h (beats %0d), required 00bb00dd", rd_data.size() ? rd_data[0] : 32'hx, rd_data.size());
        end
    endtask

    task automatic test_wrap();
        logic [1:0] r; logic [3:0] i; int h, unst, cyc; logic f;
        logic [31:0] exp_w [4];
        exp_w = '{32'hC, 32'hD, 32'hA, 32'hB};
        wq_data = '{32'hA, 32'hB, 32'hC, 32'hD}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(4'h6, 32'h38, 3, 2'b10, 3, 0, r, i, h);
        checks++; if (r !== 2'b00) begin fails++; $display("FAIL wrap_bresp: got %b, required 00", r); end
        model_write(14, 3, 2);
        axi_read(4'h7, 32'h30, 3, 2'b01, -1, 0, i, unst, cyc, f);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= rd_data.size() || rd_data[k] !== exp_w[k]) begin
                fails++;
                $display("FAIL wrap_word%0d: got %h, required %h", 12 + k, k < rd_data.size() ? rd_data[k] : 32'hx, exp_w[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] r; logic [3:0] i; int h, unst, cyc; logic f;
        wq_data.delete(); wq_strb.delete();
        for (int k = 0; k < 8; k++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
        axi_write(4'h9, 32'h80, 7, 2'b01, 7, 5, r, i, h);
        checks++; if (h != 0) begin fails++; $display("FAIL b_stall_hold: got %0d bad cycles, required 0", h); end
        checks++; if (r !== 2'b00 || i !== 4'h9) begin fails++; $display("FAIL b_stall_resp: got %b/%h, required 00/9", r, i); end
        checks++; if (awready !== 1'b1) begin fails++; $display("FAIL b_stall_awready: got %b, required 1", awready); end
        model_write(32, 7, 1);
        axi_read(4'hB, 32'h80, 7, 2'b01, 3, 3, i, unst, cyc, f);
        checks++; if (unst != 0) begin fails++; $display("FAIL r_stall_stable: got %0d unstable cycles, required 0", unst); end
        checks++; if (cyc != 11) begin fails++; $display("FAIL r_stall_cycles: got %0d, required 11", cyc); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= rd_data.size() || rd_data[k] !== model_read(32, 7, 1, k) || rd_last[k] !== (k == 7)) begin
                fails++;
                $display("FAIL r_stall_beat%0d: got %h, required %h", k, k < rd_data.size() ? rd_data[k] : 32'hx, model_read(32, 7, 1, k));
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0] r; logic [3:0] i; int h, unst, cyc; logic f;
        axi_read(4'hC, 32'h10, 1, 2'b11, -1, 0, i, unst, cyc, f);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (k >= rd_data.size() || {rd_data[k], rd_resp[k], rd_last[k]} !== {32'h0, 2'b10, k == 1}) begin
                fails++;
                $display("FAIL rsvd_read_beat%0d: got %h/%b/%b, required 0/10/%b", k, k < rd_data.size() ? rd_data[k] : 32'hx, k < rd_data.size() ? rd_resp[k] : 2'bx, k < rd_data.size() ? rd_last[k] : 1'bx, k == 1);
            end
        end
        wq_data = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(4'h4, 32'hA0, 3, 2'b01, 1, 0, r, i, h);
        checks++; if (r !== 2'b10) begin fails++; $display("FAIL early_wlast_bresp: got %b, required 10", r); end
        model_write(40, 3, 1);
        axi_write(4'h4, 32'hB0, 1, 2'b11, 1, 0, r, i, h);
        checks++; if (r !== 2'b10) begin fails++; $display("FAIL rsvd_write_bresp: got %b, required 10", r); end
        model_write(44, 1, 3);
        wq_data = '{32'hE0E0E0E0, 32'hE1E1E1E1, 32'hE2E2E2E2}; wq_strb = '{4'hF, 4'h3, 4'hC};
        axi_write(4'h8, 32'hC8, 2, 2'b10, -1, 0, r, i, h);
        checks++; if (r !== 2'b10) begin fails++; $display("FAIL badwrap_bresp: got %b, required 10", r); end
        model_write(50, 2, 2);
        axi_read(4'hD, 32'hA0, 7, 2'b01, -1, 0, i, unst, cyc, f);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= rd_data.size() || rd_data[k] !== model_read(40, 7, 1, k)) begin
                fails++;
                $display("FAIL err_mem_word%0d: got %h, required %h", 40 + k, k < rd_data.size() ? rd_data[k] : 32'hx, model_read(40, 7, 1, k));
            end
        end
        axi_read(4'hE, 32'hC8, 2, 2'b10, -1, 0, i, unst, cyc, f);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= rd_data.size() || {rd_data[k], rd_resp[k]} !== {model_read(50, 2, 2, k), 2'b10}) begin
                fails++;
                $display("FAIL badwrap_read%0d: got %h, required %h/10", k, k < rd_data.size() ? rd_data[k] : 32'hx, model_read(50, 2, 2, k));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] i; int unst, cyc; logic f;
        @(negedge aclk);
        arid = 4'h3; araddr = 32'h0; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        repeat (2) @(negedge aclk);
        checks++; if (rvalid !== 1'b1) begin fails++; $display("FAIL midread_active: rvalid got %b, required 1", rvalid); end
        areset = 1'b1;
        #1;
        checks++;
        if ({rvalid, arready, rlast, rdata} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL midread_reset: rvalid/arready/rlast/rdata got %b/%b/%b/%h, required 0/1/0/0", rvalid, arready, rlast, rdata);
        end
        @(negedge aclk);
        areset = 1'b0;
        axi_read(4'h6, 32'h40, 7, 2'b01, -1, 0, i, unst, cyc, f);
        checks++; if (f !== 1'b1 || rd_data.size() != 8) begin fails++; $display("FAIL postreset_read: beats got %0d, required 8", rd_data.size()); end
        for (int k = 0; k < 8 && k < rd_data.size(); k++) begin
            checks++;
            if (rd_data[k] !== model_read(16, 7, 1, k) || rd_last[k] !== (k == 7)) begin
                fails++;
                $display("FAIL postreset_beat%0d: got %h, required %h", k, rd_data[k], model_read(16, 7, 1, k));
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] r; logic [3:0] i, id; int h, unst, cyc; logic f;
        int len, burst, start;
        logic [31:0] addr;
        int wlens [4];
        wlens = '{1, 3, 7, 15};
        for (int t = 0; t < 10; t++) begin
            burst = $urandom_range(0, 2);
            len = (burst == 2) ? wlens[$urandom_range(0, 3)] : $urandom_range(0, 15);
            start = $urandom_range(0, 63 - len);
            addr = (start * 4) | $urandom_range(0, 3) | ($urandom & 32'hFFFFF000);
            id = 4'($urandom_range(0, 15));
            wq_data.delete(); wq_strb.delete();
            for (int k = 0; k <= len; k++) begin wq_data.push_back($urandom); wq_strb.push_back(4'($urandom_range(0, 15))); end
            axi_write(id, addr, len, burst[1:0], len, $urandom_range(0, 2), r, i, h);
            model_write(start, len, burst);
            checks++;
            if ({r, i} !== {exp_resp(burst, len), id}) begin
                fails++;
                $display("FAIL rand%0d_b: got %b/%h, required %b/%h", t, r, i, exp_resp(burst, len), id);
            end
            axi_read(~id, addr, len, burst[1:0], $urandom_range(0, len), $urandom_range(0, 2), i, unst, cyc, f);
            checks++;
            if (rd_data.size() != len + 1 || i !== ~id || unst != 0) begin
                fails++;
                $display("FAIL rand%0d_r: beats/rid/unstable got %0d/%h/%0d, required %0d/%h/0", t, rd_data.size(), i, unst, len + 1, ~id);
            end
            for (int k = 0; k <= len && k < rd_data.size(); k++) begin
                checks++;
                if ({rd_data[k], rd_resp[k], rd_last[k]} !== {model_read(start, len, burst, k), exp_resp(burst, len), k == len}) begin
                    fails++;
                    $display("FAIL rand%0d_beat%0d: got %h/%b/%b, required %h/%b/%b", t, k, rd_data[k], rd_resp[k], rd_last[k], model_read(start, len, burst, k), exp_resp(burst, len), k == len);
                end
            end
        end
        axi_read(4'hF, 32'h0, 63, 2'b01, -1, 0, i, unst, cyc, f);
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (k >= rd_data.size() || rd_data[k] !== model[k]) begin
                fails++;
                $display("FAIL region_word%0d: got %h, required %h", k, k < rd_data.size() ? rd_data[k] : 32'hx, model[k]);
            end
        end
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        init_mem();
        test_incr();
        test_strobe();
        test_wrap();
        test_backpressure();
        test_errors();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/axi4_mem_slave_responder.md
Name: axi4_mem_slave_responder

Overview:
Synthesizable AXI4 slave that answers master-issued read/write bursts from an internal word-addressed memory, as the RTL stand-in for the VIP memory-model slave in chip-level benches. It has independent write (AW/W/B) and read (AR/R) engines, one outstanding transaction each, and supports FIXED/INCR/WRAP bursts with WSTRB.

Parameters:
DATA_WIDTH, 32, data bus width in bits (power of 2, ≥32); B = log2(DATA_WIDTH/8)
ADDR_WIDTH, 32, AXI byte-address width
ID_WIDTH, 4, AXI ID width
MEM_AW, 10, log2 of memory depth in words

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
awid  in  ID_WIDTH  write ID
awaddr  in  ADDR_WIDTH  write start byte address
awlen  in  8  beats-1
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  response ID (= captured awid)
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  ID_WIDTH  read ID
araddr  in  ADDR_WIDTH  read start byte address
arlen  in  8  beats-1
arburst  in  2  burst type, same encoding as awburst
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  read ID (= captured arid)
rdata  out  DATA_WIDTH  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready

Behaviour:
- Reset: awready=arready=1; wready, bvalid, rvalid, rlast = 0; bid, rid, bresp, rresp, rdata = 0. Both FSMs return to IDLE immediately and discard any in-flight transaction. Memory contents are not cleared; beats already written stay committed. Full-size beats only (no AxSIZE); the index is addr[MEM_AW+B-1:B], the low B bits are ignored, and upper bits alias.
- Write FSM W_IDLE/W_DATA/W_RESP:
  - W_IDLE: awready=1. On the AW handshake, capture id/addr/len/burst; go to W_DATA; wready=1 from the next cycle.
  - W_DATA: each W handshake writes the bytes enabled by wstrb at the current word, then advances the address and beat count. When beat==len: wready←0, bvalid←1 next cycle; go to W_RESP.
  - W_RESP: hold bvalid/bid/bresp until bready. Then bvalid←0 and awready←1 next cycle.
- Read FSM R_IDLE/R_DATA:
  - AR handshake at cycle N gives rvalid=1 at N+1 with the first word registered.
  - rdata/rresp/rlast/rid hold stable while rvalid&!rready.
  - On an R handshake of a non-last beat, the next word loads in the same edge, so bursts run at 1 beat/cycle.
  - On the rlast beat: rvalid←0, arready←1 next cycle. rlast=1 only on beat len.
- Address step:
  - FIXED: no change.
  - INCR: +1 word, wraps modulo 2^MEM_AW.
  - WRAP: len must be 1/3/7/15. The word index wraps inside an (len+1)-aligned block.
- Error rules:
  - WRAP with any other len: SLVERR, addressed as INCR.
  - Burst 11: SLVERR; writes suppressed, reads return 0.
  - wlast asserted before beat len, or missing on beat len: exactly len+1 beats still accepted, bresp=SLVERR.
- Read and write engines run concurrently. A same-word read load and write in the same cycle returns the old data.

Test Plan:
1. INCR write awaddr=0x10, len=3, data 0x11111111..0x44444444, wstrb=F → bresp=00, bid=awid. INCR read of the same → four beats in order, rlast on the 4th, rresp=00, rid=arid.
2. Word at 0x20 = 0, then write 0xAABBCCDD with wstrb=0101 → read returns 0x00BB00DD.
3. WRAP write at 0x38, len=3, data A,B,C,D → words 14,15,12,13 written. INCR read at 0x30, len=3 → C,D,A,B.
4. Backpressure: rready low 3 cycles mid-burst → R outputs stable, no beat lost. bready low 5 cycles → bvalid held, awready=0 throughout.
5. arburst=11, len=1 → 2 beats of 0 with rresp=10. len=3 write with wlast on beat 1 → 4 beats accepted, bresp=10, memory updated.
6. Assert areset during beat 2 of an 8-beat read → rvalid=0 immediately. arready=1 and a new read completes correctly after release.
